// File: rtl/bsg_manycore_lock_pkg.sv
// Shared types and constants for the AMO lock requester and its lock tracker.
package bsg_manycore_lock_pkg;

    typedef enum logic [2:0] {
        LOCK_REQ_IDLE,
        LOCK_REQ_SEND_ACQ,
        LOCK_REQ_WAIT_ACQ,
        LOCK_REQ_BACKOFF,
        LOCK_REQ_HELD,
        LOCK_REQ_SEND_REL,
        LOCK_REQ_WAIT_REL
    } lock_req_state_e;

    typedef enum logic {
        LOCK_ACQUIRE = 1'b0,
        LOCK_RELEASE = 1'b1
    } lock_op_e;

    // Lock word values: a swap returning FREE means we won the lock.
    localparam int LOCK_TAKEN_VAL = 1;
    localparam int LOCK_FREE_VAL  = 0;

    // bsg_cache packet opcode field.
    localparam int              CACHE_OPCODE_WIDTH = 6;
    localparam logic [5:0]      CACHE_OP_AMOSWAP_W = 6'b100000;

    // Packet layout {opcode, addr, data, mask}, mask is one bit per byte.
    function automatic int cache_pkt_width(int addr_width, int data_width);
        return CACHE_OPCODE_WIDTH + addr_width + data_width + (data_width >> 3);
    endfunction

endpackage

// File: rtl/lock_backoff_timer.sv
// Exponential backoff: holds the current backoff value and a countdown timer.
// load copies the backoff into the timer and doubles the backoff (saturating
// at all ones); tick counts the timer down until it reaches 1 (expired).
module lock_backoff_timer #(
    parameter int width_p = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic init,
    input  logic load,
    input  logic tick,
    output logic expired
);

    logic [width_p-1:0] backoff;
    logic [width_p-1:0] timer;

    assign expired = (timer == width_p'(1));

    // Backoff value and countdown; a fresh acquire restarts the backoff at 1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            backoff <= width_p'(1);
            timer   <= width_p'(1);
        end else if (init) begin
            backoff <= width_p'(1);
        end else if (load) begin
            timer   <= backoff;
            backoff <= backoff[width_p-1] ? '1 : (backoff << 1);
        end else if (tick && !expired) begin
            timer   <= timer - width_p'(1);
        end
    end

endmodule

// File: rtl/amo_lock_requester.sv
// Initiator side of the AMO lock protocol: turns acquire/release commands into
// AMOSWAP_W cache packets, retries lost acquires with exponential backoff and
// drains any response that arrives when none is expected.
module amo_lock_requester
    import bsg_manycore_lock_pkg::*;
#(
    parameter int cache_addr_width_p = 32,
    parameter int data_width_p       = 32,
    parameter int backoff_width_p    = 8,
    parameter int retry_width_p      = 16,
    localparam int bsg_cache_pkt_width_lp = cache_pkt_width(cache_addr_width_p, data_width_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              lock_v_i,
    input  logic                              lock_op_i,
    input  logic [cache_addr_width_p-1:0]     lock_addr_i,
    output logic                              lock_ready_o,
    output logic                              done_v_o,
    output logic                              done_op_o,
    output logic [retry_width_p-1:0]          retries_o,
    output logic                              err_o,
    output logic                              v_o,
    output logic [bsg_cache_pkt_width_lp-1:0] cache_pkt_o,
    input  logic                              ready_i,
    input  logic                              v_i,
    input  logic [data_width_p-1:0]           data_i,
    output logic                              yumi_o
);

    typedef struct packed {
        logic [CACHE_OPCODE_WIDTH-1:0]   opcode;
        logic [cache_addr_width_p-1:0]   addr;
        logic [data_width_p-1:0]         data;
        logic [(data_width_p>>3)-1:0]    mask;
    } cache_pkt_s;

    lock_req_state_e                 state;
    logic [cache_addr_width_p-1:0]   held_addr;
    logic [retry_width_p-1:0]        retry_cnt;
    cache_pkt_s                      pkt;
    logic                            accept;
    logic                            in_wait;
    logic                            stray;
    logic                            acq_lost;
    logic                            backoff_expired;

    assign accept   = lock_v_i & lock_ready_o;
    assign in_wait  = (state == LOCK_REQ_WAIT_ACQ) || (state == LOCK_REQ_WAIT_REL);
    assign stray    = v_i & ~in_wait;
    assign acq_lost = (state == LOCK_REQ_WAIT_ACQ) && v_i
                      && (data_i != data_width_p'(LOCK_FREE_VAL));

    // Every response is consumed: expected ones in WAIT_*, stray ones are dropped.
    assign yumi_o       = reset_n_i & v_i;
    assign lock_ready_o = reset_n_i & ((state == LOCK_REQ_IDLE) || (state == LOCK_REQ_HELD));
    assign v_o          = (state == LOCK_REQ_SEND_ACQ) || (state == LOCK_REQ_SEND_REL);

    // Packet fields come straight from registered state, so they hold under backpressure.
    always_comb begin
        pkt        = '0;
        pkt.opcode = CACHE_OP_AMOSWAP_W;
        pkt.addr   = held_addr;
        pkt.data   = (state == LOCK_REQ_SEND_REL) ? data_width_p'(LOCK_FREE_VAL)
                                                  : data_width_p'(LOCK_TAKEN_VAL);
        pkt.mask   = '1;
    end
    assign cache_pkt_o = pkt;

    lock_backoff_timer #(.width_p(backoff_width_p)) backoff_timer (
        .clk     (clk_i),
        .reset_n (reset_n_i),
        .init    (accept && (state == LOCK_REQ_IDLE) && (lock_op_i == LOCK_ACQUIRE)),
        .load    (acq_lost),
        .tick    (state == LOCK_REQ_BACKOFF),
        .expired (backoff_expired)
    );

    // Main protocol FSM with registered completion/error pulses.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state     <= LOCK_REQ_IDLE;
            held_addr <= '0;
            retry_cnt <= '0;
            retries_o <= '0;
            done_v_o  <= 1'b0;
            done_op_o <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            done_v_o <= 1'b0;
            err_o    <= stray;
            unique case (state)
                LOCK_REQ_IDLE: begin
                    if (accept) begin
                        if (lock_op_i == LOCK_ACQUIRE) begin
                            held_addr <= lock_addr_i;
                            retry_cnt <= '0;
                            state     <= LOCK_REQ_SEND_ACQ;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                LOCK_REQ_SEND_ACQ: if (ready_i) state <= LOCK_REQ_WAIT_ACQ;
                LOCK_REQ_WAIT_ACQ: begin
                    if (v_i) begin
                        if (acq_lost) begin
                            if (retry_cnt != '1) retry_cnt <= retry_cnt + retry_width_p'(1);
                            state <= LOCK_REQ_BACKOFF;
                        end else begin
                            done_v_o  <= 1'b1;
                            done_op_o <= LOCK_ACQUIRE;
                            retries_o <= retry_cnt;
                            state     <= LOCK_REQ_HELD;
                        end
                    end
                end
                LOCK_REQ_BACKOFF: if (backoff_expired) state <= LOCK_REQ_SEND_ACQ;
                LOCK_REQ_HELD: begin
                    if (accept) begin
                        if (lock_op_i == LOCK_RELEASE) state <= LOCK_REQ_SEND_REL;
                        else                           err_o <= 1'b1;
                    end
                end
                LOCK_REQ_SEND_REL: if (ready_i) state <= LOCK_REQ_WAIT_REL;
                LOCK_REQ_WAIT_REL: begin
                    if (v_i) begin
                        done_v_o  <= 1'b1;
                        done_op_o <= LOCK_RELEASE;
                        state     <= LOCK_REQ_IDLE;
                        if (data_i != data_width_p'(LOCK_TAKEN_VAL)) err_o <= 1'b1;
                    end
                end
                default: state <= LOCK_REQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amo_lock_requester.sv
// Self-checking bench for amo_lock_requester: directed protocol scenarios plus
// randomized acquire/release rounds against a transaction-level model.
module tb_amo_lock_requester;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int BW   = 3;
    localparam int RW   = 2;
    localparam int PW   = 6 + AW + DW + DW / 8;
    localparam int BMAX = (1 << BW) - 1;
    localparam int RMAX = (1 << RW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          lock_v, lock_op;
    logic [AW-1:0] lock_addr;
    logic          lock_ready_o, done_v_o, done_op_o, err_o, v_o, yumi_o;
    logic [RW-1:0] retries_o;
    logic [PW-1:0] cache_pkt;
    logic          ready, v_in;
    logic [DW-1:0] data_in;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int exp_hs  = 0;
    logic [AW-1:0] held;

    amo_lock_requester #(
        .cache_addr_width_p(AW), .data_width_p(DW),
        .backoff_width_p(BW), .retry_width_p(RW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .lock_v_i(lock_v), .lock_op_i(lock_op), .lock_addr_i(lock_addr),
        .lock_ready_o(lock_ready_o), .done_v_o(done_v_o), .done_op_o(done_op_o),
        .retries_o(retries_o), .err_o(err_o),
        .v_o(v_o), .cache_pkt_o(cache_pkt), .ready_i(ready),
        .v_i(v_in), .data_i(data_in), .yumi_o(yumi_o)
    );

    always #5 clk = ~clk;

    // Count accepted cache packets independently of the stimulus.
    always @(posedge clk) if (reset_n && v_o && ready) hs_cnt <= hs_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: k-th retry waits min(2^k, 2^BW-1) idle cycles.
    function automatic int exp_gap(input int a);
        int g = 1 << a;
        return (g > BMAX) ? BMAX : g;
    endfunction

    function automatic int exp_retries(input int k);
        return (k > RMAX) ? RMAX : k;
    endfunction

    function automatic logic [PW-1:0] exp_pkt(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [5:0]      op   = 6'b100000;
        logic [DW/8-1:0] mask = '1;
        return {op, a, d, mask};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the packet under backpressure for dly cycles, then hand it over.
    task automatic send_pkt(input logic [PW-1:0] p, input int dly);
        ready = 1'b0;
        for (int i = 0; i < dly; i++) begin
            chk("bp_v_o", 64'(v_o), 64'(1));
            chk("bp_pkt", 64'(cache_pkt), 64'(p));
            step();
        end
        chk("send_v_o", 64'(v_o), 64'(1));
        chk("send_pkt", 64'(cache_pkt), 64'(p));
        ready = 1'b1;
        step();
        ready = 1'b0;
        exp_hs++;
    endtask

    // Return one response after dly idle cycles; it must be consumed at once.
    task automatic respond(input logic [DW-1:0] d, input int dly);
        for (int i = 0; i < dly; i++) begin
            chk("wait_v_o", 64'(v_o), 64'(0));
            step();
        end
        v_in = 1'b1;
        data_in = d;
        #1;
        chk("resp_yumi", 64'(yumi_o), 64'(1));
        step();
        v_in = 1'b0;
    endtask

    task automatic do_acquire(input logic [AW-1:0] addr, input int nfail,
                              input int bp_min, input int bp_max);
        logic [DW-1:0] d;
        lock_v = 1'b1; lock_op = 1'b0; lock_addr = addr;
        #1;
        chk("acq_ready", 64'(lock_ready_o), 64'(1));
        step();
        lock_v = 1'b0;
        lock_addr = AW'($urandom);
        chk("acq_latency_v_o", 64'(v_o), 64'(1));
        for (int a = 0; a <= nfail; a++) begin
            send_pkt(exp_pkt(addr, DW'(1)), $urandom_range(bp_max, bp_min));
            if (a < nfail) begin
                d = $urandom;
                if (d == 0) d = 1;
            end else begin
                d = 0;
            end
            respond(d, $urandom_range(3, 0));
            if (a < nfail) begin
                for (int i = 0; i < exp_gap(a); i++) begin
                    chk("backoff_gap", 64'(v_o), 64'(0));
                    chk("backoff_no_done", 64'(done_v_o), 64'(0));
                    step();
                end
                chk("backoff_resend", 64'(v_o), 64'(1));
            end
        end
        chk("acq_done", 64'(done_v_o), 64'(1));
        chk("acq_done_op", 64'(done_op_o), 64'(0));
        chk("acq_retries", 64'(retries_o), 64'(exp_retries(nfail)));
        chk("acq_err", 64'(err_o), 64'(0));
        step();
        chk("acq_done_pulse", 64'(done_v_o), 64'(0));
        chk("held_ready", 64'(lock_ready_o), 64'(1));
        chk("acq_pkt_count", 64'(hs_cnt), 64'(exp_hs));
        held = addr;
    endtask

    task automatic do_release(input logic [DW-1:0] resp, input int bp_min, input int bp_max);
        lock_v = 1'b1; lock_op = 1'b1; lock_addr = 16'h0080;
        #1;
        chk("rel_ready", 64'(lock_ready_o), 64'(1));
        step();
        lock_v = 1'b0;
        chk("rel_latency_v_o", 64'(v_o), 64'(1));
        send_pkt(exp_pkt(held, DW'(0)), $urandom_range(bp_max, bp_min));
        respond(resp, $urandom_range(3, 0));
        chk("rel_done", 64'(done_v_o), 64'(1));
        chk("rel_done_op", 64'(done_op_o), 64'(1));
        chk("rel_err", 64'(err_o), 64'(resp != DW'(1)));
        step();
        chk("rel_done_pulse", 64'(done_v_o), 64'(0));
        chk("rel_err_pulse", 64'(err_o), 64'(0));
        chk("idle_ready", 64'(lock_ready_o), 64'(1));
        chk("rel_pkt_count", 64'(hs_cnt), 64'(exp_hs));
    endtask

    // Command or stray response that must only pulse err_o.
    task automatic expect_err_only(input string tag);
        chk({tag, "_err"}, 64'(err_o), 64'(1));
        chk({tag, "_v_o"}, 64'(v_o), 64'(0));
        chk({tag, "_done"}, 64'(done_v_o), 64'(0));
        chk({tag, "_ready"}, 64'(lock_ready_o), 64'(1));
        step();
        chk({tag, "_err_pulse"}, 64'(err_o), 64'(0));
    endtask

    initial begin
        logic [DW-1:0] resp;
        reset_n = 1'b0; lock_v = 1'b0; lock_op = 1'b0; lock_addr = '0;
        ready = 1'b0; v_in = 1'b1; data_in = '0; held = '0;
        step();
        step();
        #1;
        chk("rst_v_o", 64'(v_o), 64'(0));
        chk("rst_yumi", 64'(yumi_o), 64'(0));
        chk("rst_ready", 64'(lock_ready_o), 64'(0));
        chk("rst_done", 64'(done_v_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_retries", 64'(retries_o), 64'(0));
        v_in = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(lock_ready_o), 64'(1));
        step();

        // Uncontended acquire, then errors while held.
        do_acquire(16'h0040, 0, 0, 0);
        lock_v = 1'b1; lock_op = 1'b0; lock_addr = 16'h0123;
        step();
        lock_v = 1'b0;
        expect_err_only("acq_in_held");
        v_in = 1'b1; data_in = $urandom;
        #1;
        chk("stray_held_yumi", 64'(yumi_o), 64'(1));
        step();
        v_in = 1'b0;
        expect_err_only("stray_in_held");

        // Release uses the held address, not lock_addr_i.
        do_release(DW'(1), 0, 0);
        lock_v = 1'b1; lock_op = 1'b1; lock_addr = 16'h0040;
        step();
        lock_v = 1'b0;
        expect_err_only("rel_in_idle");

        // Contended: two losses, then release of an unheld lock.
        do_acquire(16'h0040, 2, 0, 0);
        do_release(DW'(0), 0, 0);

        // Backpressure for exactly 5 cycles.
        do_acquire(16'h0100, 0, 5, 5);
        do_release(DW'(1), 5, 5);

        // Backoff and retry counter saturation.
        do_acquire(16'h0200, 5, 0, 2);
        do_release(DW'(1), 0, 2);

        // Reset while waiting for an acquire response.
        lock_v = 1'b1; lock_op = 1'b0; lock_addr = 16'h0300;
        step();
        lock_v = 1'b0;
        send_pkt(exp_pkt(16'h0300, DW'(1)), 0);
        reset_n = 1'b0;
        step();
        chk("midrst_v_o", 64'(v_o), 64'(0));
        chk("midrst_ready", 64'(lock_ready_o), 64'(0));
        chk("midrst_retries", 64'(retries_o), 64'(0));
        chk("midrst_done", 64'(done_v_o), 64'(0));
        reset_n = 1'b1;
        #1;
        chk("midrst_idle_ready", 64'(lock_ready_o), 64'(1));
        v_in = 1'b1; data_in = '0;
        #1;
        chk("late_resp_yumi", 64'(yumi_o), 64'(1));
        step();
        v_in = 1'b0;
        expect_err_only("late_resp");
        lock_v = 1'b1; lock_op = 1'b1; lock_addr = 16'h0300;
        step();
        lock_v = 1'b0;
        expect_err_only("rel_after_rst");

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            do_acquire(AW'($urandom) & ~AW'(3), $urandom_range(6, 0), 0, 3);
            case ($urandom_range(4, 0))
                0:       resp = '0;
                1:       resp = DW'($urandom_range(100, 2));
                default: resp = DW'(1);
            endcase
            do_release(resp, 0, 3);
        end

        chk("total_pkt_count", 64'(hs_cnt), 64'(exp_hs));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
